length_match_scorer: RTL



---
 rtl/length_match_scorer_pkg.sv | 33 +++
 rtl/row_match_count.sv | 26 ++
 rtl/length_match_scorer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/length_match_scorer_pkg.sv
// Shared definitions for the length match scorer: tile geometry, score width,
// FSM state encoding, result payload and the row-slice helper.
package length_match_scorer_pkg;

   localparam int unsigned TILE_W    = 256;
   localparam int unsigned ROW_W     = 16;
   localparam int unsigned NUM_ROWS  = 16;
   localparam int unsigned SCORE_W   = 9;
   localparam int unsigned ROW_IDX_W = 4;
   localparam int unsigned ROW_CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCORE_Q = 2'd1,
      ST_SCORE_H = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef struct packed {
      logic               half;
      logic               miss;
      logic [SCORE_W-1:0] score;
   } result_t;

   // Row r occupies bits [TILE_W-1-ROW_W*r -: ROW_W]; row 0 is the MSB row.
   function automatic logic [ROW_W-1:0] row_slice(input logic [TILE_W-1:0]    vec,
                                                  input logic [ROW_IDX_W-1:0] r);
      int unsigned base;
      base = (NUM_ROWS - 1 - 32'(r)) * ROW_W;
      return vec[base +: ROW_W];
   endfunction

endpackage

// File: rtl/row_match_count.sv
// Combinational per-row match counter: number of equal bit positions
// (XNOR popcount) between one tile row and one template row.
//   tile_row    : 16-bit row of the captured tile
//   tmpl_row    : 16-bit row of the selected template
//   match_cnt_c : 0..16 matching bits
module row_match_count
   import length_match_scorer_pkg::*;
(
   input  logic [ROW_W-1:0]     tile_row,
   input  logic [ROW_W-1:0]     tmpl_row,
   output logic [ROW_CNT_W-1:0] match_cnt_c
);

   logic [ROW_W-1:0] eq_bits;

   assign eq_bits = ~(tile_row ^ tmpl_row);

   // Popcount of the equality mask.
   always_comb begin
      match_cnt_c = '0;
      for (int i = 0; i < ROW_W; i++) begin
         match_cnt_c = match_cnt_c + ROW_CNT_W'(eq_bits[i]);
      end
   end

endmodule

// File: rtl/length_match_scorer.sv
// Scores one captured 16x16 note tile against the quarter and half length
// templates (one row per cycle, quarter first), then reports the better length.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   tile_in/valid/ready: tile capture handshake (accepted only in IDLE)
//   tmpl_sel           : length mux select, 0=quarter, 1=half
//   tmpl_map           : template returned by the mux for the current tmpl_sel
//   result_valid/ready : result handshake
//   result_half        : 1 when half beats quarter (tie -> quarter)
//   result_miss        : winning score below MIN_SCORE
//   result_score       : winning score 0..256
// Optional (LEN_MATCH_SCORES_EN defined): score_q / score_h export both final
// accumulators alongside the result.
module length_match_scorer
   import length_match_scorer_pkg::*;
#(
   parameter int unsigned MIN_SCORE = 200
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TILE_W-1:0]  tile_in,
   input  logic               tile_valid,
   output logic               tile_ready,
   output logic               tmpl_sel,
   input  logic [TILE_W-1:0]  tmpl_map,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_half,
   output logic               result_miss,
   output logic [SCORE_W-1:0] result_score
`ifdef LEN_MATCH_SCORES_EN
   ,
   output logic [SCORE_W-1:0] score_q,
   output logic [SCORE_W-1:0] score_h
`endif
);

   state_t                 state_q, state_d;
   logic [ROW_IDX_W-1:0]   row_q;
   logic [TILE_W-1:0]      tile_q;
   logic [SCORE_W-1:0]     acc_quarter, acc_half;
   logic [ROW_CNT_W-1:0]   row_cnt_c;
   logic [SCORE_W-1:0]     acc_quarter_sum_c, acc_half_sum_c;
   logic                   row_last_c;
   logic                   tile_ready_d, tmpl_sel_d, result_valid_d;
   result_t                res_c;

   row_match_count u_row_match_count (
      .tile_row    (row_slice(tile_q, row_q)),
      .tmpl_row    (row_slice(tmpl_map, row_q)),
      .match_cnt_c (row_cnt_c)
   );

   assign row_last_c        = (row_q == ROW_IDX_W'(NUM_ROWS - 1));
   assign acc_quarter_sum_c = acc_quarter + SCORE_W'(row_cnt_c);
   assign acc_half_sum_c    = acc_half + SCORE_W'(row_cnt_c);

   // Decision on the last half row, using the half accumulator including that row.
   always_comb begin
      res_c       = '0;
      res_c.half  = (acc_half_sum_c > acc_quarter);
      res_c.score = res_c.half ? acc_half_sum_c : acc_quarter;
      res_c.miss  = (res_c.score < SCORE_W'(MIN_SCORE));
   end

   // Next state, and handshake/select outputs decoded from the next state so
   // their registered copies track the state register exactly.
   always_comb begin
      state_d        = state_q;
      tile_ready_d   = 1'b0;
      tmpl_sel_d     = 1'b0;
      result_valid_d = 1'b0;
      case (state_q)
         ST_IDLE:    if (tile_valid)   state_d = ST_SCORE_Q;
         ST_SCORE_Q: if (row_last_c)   state_d = ST_SCORE_H;
         ST_SCORE_H: if (row_last_c)   state_d = ST_DONE;
         ST_DONE:    if (result_ready) state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
      tile_ready_d   = (state_d == ST_IDLE);
      tmpl_sel_d     = (state_d == ST_SCORE_H);
      result_valid_d = (state_d == ST_DONE);
   end

   // State register and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tile_ready   <= 1'b1;
         tmpl_sel     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         tile_ready   <= tile_ready_d;
         tmpl_sel     <= tmpl_sel_d;
         result_valid <= result_valid_d;
      end
   end

   // Datapath: tile capture, row walk, accumulation and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_q       <= '0;
         row_q        <= '0;
         acc_quarter  <= '0;
         acc_half     <= '0;
         result_half  <= 1'b0;
         result_miss  <= 1'b0;
         result_score <= '0;
`ifdef LEN_MATCH_SCORES_EN
         score_q      <= '0;
         score_h      <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tile_valid) begin
                  tile_q      <= tile_in;
                  row_q       <= '0;
                  acc_quarter <= '0;
                  acc_half    <= '0;
               end
            end
            ST_SCORE_Q: begin
               acc_quarter <= acc_quarter_sum_c;
               row_q       <= row_q + ROW_IDX_W'(1);
            end
            ST_SCORE_H: begin
               acc_half <= acc_half_sum_c;
               row_q    <= row_q + ROW_IDX_W'(1);
               if (row_last_c) begin
                  result_half  <= res_c.half;
                  result_miss  <= res_c.miss;
                  result_score <= res_c.score;
`ifdef LEN_MATCH_SCORES_EN
                  score_q      <= acc_quarter;
                  score_h      <= acc_half_sum_c;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
